// File: rtl/cartas_pkg.sv
// Shared definitions for the card-selection block and the pair verifier.
//   NUM_CARTAS       : cards on the board
//   CERRADA/ABIERTA/EMPAREJADA : 2-bit card states (11 is never selectable)
//   card_t / board_t : 5-bit card {symbol[4:2], state[1:0]} and 16-card board
//   fsm_t            : turn FSM states
//   all_matched()    : true when every card on a board is EMPAREJADA
package cartas_pkg;

    localparam int NUM_CARTAS = 16;
    localparam int CUR_W      = $clog2(NUM_CARTAS);

    localparam logic [1:0] CERRADA    = 2'b00;
    localparam logic [1:0] ABIERTA    = 2'b01;
    localparam logic [1:0] EMPAREJADA = 2'b10;

    typedef logic [4:0] card_t;
    typedef card_t [0:NUM_CARTAS-1] board_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UNA     = 3'd1,
        MOSTRAR = 3'd2,
        PEDIR   = 3'd3,
        ESPERAR = 3'd4,
        FIN     = 3'd5
    } fsm_t;

    function automatic logic all_matched(input board_t b);
        logic r;
        r = 1'b1;
        for (int i = 0; i < NUM_CARTAS; i++)
            if (b[i][1:0] != EMPAREJADA) r = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/seleccionar_cartas_if.sv
// Bundle between the card-selection block and its environment.
//   Inputs to the block : cargar, arr_cards_in, btn_izq/der/sel,
//                         arr_verif_in, verif_done, verif_pareja
//   Outputs of the block: arr_cards_out, start_verif, cursor,
//                         turno_fin, pareja, intentos, juego_fin
//   slave  : seen by seleccionar_cartas
//   master : seen by whoever drives the buttons / verifier
interface seleccionar_cartas_if;
    import cartas_pkg::*;

    logic                  cargar;
    board_t                arr_cards_in;
    logic                  btn_izq;
    logic                  btn_der;
    logic                  btn_sel;
    board_t                arr_verif_in;
    logic                  verif_done;
    logic                  verif_pareja;

    board_t                arr_cards_out;
    logic                  start_verif;
    logic [CUR_W-1:0]      cursor;
    logic                  turno_fin;
    logic                  pareja;
    logic [7:0]            intentos;
    logic                  juego_fin;

    modport slave (
        input  cargar, arr_cards_in, btn_izq, btn_der, btn_sel,
               arr_verif_in, verif_done, verif_pareja,
        output arr_cards_out, start_verif, cursor, turno_fin, pareja,
               intentos, juego_fin
    );

    modport master (
        output cargar, arr_cards_in, btn_izq, btn_der, btn_sel,
               arr_verif_in, verif_done, verif_pareja,
        input  arr_cards_out, start_verif, cursor, turno_fin, pareja,
               intentos, juego_fin
    );

endinterface

// File: rtl/temporizador_mostrar.sv
// Show-delay timer: keeps both open cards visible for SHOW_CYCLES cycles.
//   clk, rst  : clock, async active-low reset
//   load_i    : preload on the cycle the FSM enters MOSTRAR
//   count_i   : high while in MOSTRAR, decrements towards zero
//   expire_o  : high on the last MOSTRAR cycle
// Loading N-1 and expiring at zero gives exactly N cycles; 0 and 1 both
// collapse to a single cycle.
module temporizador_mostrar #(
    parameter int unsigned SHOW_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic count_i,
    output logic expire_o
);

    localparam int W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [W-1:0] LOAD_V = (SHOW_CYCLES > 1) ? W'(SHOW_CYCLES - 1) : '0;
    localparam logic [W-1:0] ONE    = W'(1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i)
            count_d = LOAD_V;
        else if (count_i && count_q != '0)
            count_d = count_q - ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

    assign expire_o = (count_q == '0);

endmodule

// File: rtl/seleccionar_cartas.sv
// Memory-game turn controller: moves a cursor over a 16-card board, opens
// two cards, shows them, asks the pair verifier to judge them and takes
// back the verified board.
//   clk, rst : clock, async active-low reset
//   bus      : seleccionar_cartas_if.slave (load, buttons, verifier
//              handshake in; board, cursor, pulses, counters out)
// start_verif, turno_fin and pareja are registered one-cycle pulses.
module seleccionar_cartas
    import cartas_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES = 25_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    seleccionar_cartas_if.slave  bus
);

    localparam logic [CUR_W-1:0] CUR_ONE = CUR_W'(1);

    fsm_t             state_q, state_d;
    board_t           board_q, board_d;
    logic [CUR_W-1:0] cursor_q, cursor_d;
    logic [7:0]       intentos_q, intentos_d;
    logic             start_verif_q, start_verif_d;
    logic             turno_fin_q, turno_fin_d;
    logic             pareja_q, pareja_d;
    logic             sel_ok;
    logic             show_load, show_count, show_exp;

    // A select only counts on a closed card under the pre-move cursor.
    assign sel_ok     = bus.btn_sel && (board_q[cursor_q][1:0] == CERRADA);
    assign show_count = (state_q == MOSTRAR);

    temporizador_mostrar #(.SHOW_CYCLES(SHOW_CYCLES)) u_tmr (
        .clk      (clk),
        .rst      (rst),
        .load_i   (show_load),
        .count_i  (show_count),
        .expire_o (show_exp)
    );

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        if (bus.cargar) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (sel_ok) state_d = UNA;
                UNA:     if (sel_ok) state_d = MOSTRAR;
                MOSTRAR: if (show_exp) state_d = PEDIR;
                PEDIR:   state_d = ESPERAR;
                ESPERAR: if (bus.verif_done)
                             state_d = all_matched(bus.arr_verif_in) ? FIN : IDLE;
                FIN:     state_d = FIN;
                default: state_d = IDLE;
            endcase
        end
    end

    // ---- FSM: outputs (next values of the registered pulses) ----
    always_comb begin
        start_verif_d = !bus.cargar && (state_q == PEDIR);
        turno_fin_d   = !bus.cargar && (state_q == ESPERAR) && bus.verif_done;
        pareja_d      = turno_fin_d && bus.verif_pareja;
        show_load     = !bus.cargar && (state_q == UNA) && sel_ok;
    end

    // ---- Board / cursor / attempt counter ----
    // Outside IDLE/UNA the board only changes on an accepted verif_done,
    // which keeps it frozen from MOSTRAR until the verdict arrives.
    always_comb begin
        board_d    = board_q;
        cursor_d   = cursor_q;
        intentos_d = intentos_q;
        if (bus.cargar) begin
            board_d    = bus.arr_cards_in;
            cursor_d   = '0;
            intentos_d = '0;
        end else begin
            case (state_q)
                IDLE, UNA: begin
                    if (bus.btn_sel) begin
                        // Select wins over a simultaneous move.
                        if (sel_ok)
                            board_d[cursor_q] = {board_q[cursor_q][4:2], ABIERTA};
                    end else if (bus.btn_izq && !bus.btn_der) begin
                        cursor_d = cursor_q - CUR_ONE;  // 0 wraps to 15
                    end else if (bus.btn_der && !bus.btn_izq) begin
                        cursor_d = cursor_q + CUR_ONE;  // 15 wraps to 0
                    end
                end
                ESPERAR: begin
                    if (bus.verif_done) begin
                        board_d = bus.arr_verif_in;
                        if (intentos_q != 8'hFF) intentos_d = intentos_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            board_q       <= '0;
            cursor_q      <= '0;
            intentos_q    <= '0;
            start_verif_q <= 1'b0;
            turno_fin_q   <= 1'b0;
            pareja_q      <= 1'b0;
        end else begin
            board_q       <= board_d;
            cursor_q      <= cursor_d;
            intentos_q    <= intentos_d;
            start_verif_q <= start_verif_d;
            turno_fin_q   <= turno_fin_d;
            pareja_q      <= pareja_d;
        end
    end

    assign bus.arr_cards_out = board_q;
    assign bus.cursor        = cursor_q;
    assign bus.intentos      = intentos_q;
    assign bus.start_verif   = start_verif_q;
    assign bus.turno_fin     = turno_fin_q;
    assign bus.pareja        = pareja_q;
    assign bus.juego_fin     = (state_q == FIN);

endmodule

// File: tb/tb_seleccionar_cartas.sv
// Directed bench for seleccionar_cartas with SHOW_CYCLES = 4 and a small
// pair-verifier model driven from the bench.
module tb_seleccionar_cartas;
    import cartas_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   passed = 0;

    board_t     b0;
    board_t     exp_board;
    logic [7:0] exp_intentos;

    seleccionar_cartas_if bus ();

    seleccionar_cartas #(.SHOW_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pulse(input logic izq, input logic der, input logic sel);
        bus.btn_izq = izq;
        bus.btn_der = der;
        bus.btn_sel = sel;
        tick();
        bus.btn_izq = 1'b0;
        bus.btn_der = 1'b0;
        bus.btn_sel = 1'b0;
    endtask

    function automatic board_t mk_board();
        board_t b;
        for (int i = 0; i < NUM_CARTAS; i++) b[i] = {3'(i / 2), CERRADA};
        return b;
    endfunction

    task automatic load_board(input board_t b);
        bus.arr_cards_in = b;
        bus.cargar = 1'b1;
        tick();
        bus.cargar = 1'b0;
        exp_board = b;
        exp_intentos = 8'd0;
    endtask

    task automatic goto_card(input int target);
        int n;
        n = 0;
        while (int'(bus.cursor) != target && n < 32) begin
            if (4'(target - int'(bus.cursor)) <= 4'd8) pulse(1'b0, 1'b1, 1'b0);
            else                                      pulse(1'b1, 1'b0, 1'b0);
            n++;
        end
        chk("goto", 80'(bus.cursor), 80'(target));
    endtask

    // Open card c if it is closed; otherwise the board must stay as is.
    task automatic sel_card(input int c);
        goto_card(c);
        pulse(1'b0, 1'b0, 1'b1);
        if (exp_board[c][1:0] == CERRADA) exp_board[c] = {exp_board[c][4:2], ABIERTA};
        chk("sel_board", bus.arr_cards_out, exp_board);
    endtask

    // Waits for start_verif, optionally pokes buttons in ESPERAR, then plays
    // the verifier: equal symbols become matched, otherwise close again.
    task automatic resolve(input int a, input int b, input int exp_lat, input logic noise);
        int   n;
        logic match;
        n = 0;
        while (!bus.start_verif && n < 40) begin
            tick();
            n++;
        end
        chk("show_latency", 80'(n), 80'(exp_lat));
        chk("frozen_board", bus.arr_cards_out, exp_board);
        if (noise) begin
            pulse(1'b1, 1'b0, 1'b1);
            chk("esperar_btn_cursor", 80'(bus.cursor), 80'(b));
            chk("esperar_btn_board", bus.arr_cards_out, exp_board);
        end
        match = (exp_board[a][4:2] == exp_board[b][4:2]);
        exp_board[a] = {exp_board[a][4:2], match ? EMPAREJADA : CERRADA};
        exp_board[b] = {exp_board[b][4:2], match ? EMPAREJADA : CERRADA};
        bus.arr_verif_in = exp_board;
        bus.verif_done = 1'b1;
        bus.verif_pareja = match;
        tick();
        bus.verif_done = 1'b0;
        bus.verif_pareja = 1'b0;
        if (exp_intentos != 8'hFF) exp_intentos = exp_intentos + 8'd1;
        chk("turno_fin", 80'(bus.turno_fin), 80'(1));
        chk("pareja", 80'(bus.pareja), 80'(match));
        chk("intentos", 80'(bus.intentos), 80'(exp_intentos));
        chk("verif_board", bus.arr_cards_out, exp_board);
        tick();
        chk("turno_fin_pulse", 80'(bus.turno_fin), 80'(0));
    endtask

    task automatic play_pair(input int a, input int b);
        sel_card(a);
        sel_card(b);
        resolve(a, b, 5, 1'b0);
    endtask

    initial begin
        board_t full;
        rst = 1'b0;
        bus.cargar = 1'b0;
        bus.arr_cards_in = '0;
        bus.btn_izq = 1'b0;
        bus.btn_der = 1'b0;
        bus.btn_sel = 1'b0;
        bus.arr_verif_in = '0;
        bus.verif_done = 1'b0;
        bus.verif_pareja = 1'b0;
        b0 = mk_board();
        exp_board = '0;
        exp_intentos = 8'd0;

        // Reset state
        tick();
        tick();
        chk("rst_board", bus.arr_cards_out, 80'(0));
        chk("rst_cursor", 80'(bus.cursor), 80'(0));
        chk("rst_intentos", 80'(bus.intentos), 80'(0));
        chk("rst_pulses", 80'({bus.start_verif, bus.turno_fin, bus.pareja}), 80'(0));
        chk("rst_juego_fin", 80'(bus.juego_fin), 80'(0));
        rst = 1'b1;
        tick();

        // Load and cursor wrap
        load_board(b0);
        chk("load_board", bus.arr_cards_out, b0);
        chk("load_cursor", 80'(bus.cursor), 80'(0));
        pulse(1'b0, 1'b1, 1'b0);
        chk("right_1", 80'(bus.cursor), 80'(1));
        for (int i = 1; i < 16; i++) pulse(1'b0, 1'b1, 1'b0);
        chk("right_16_wrap", 80'(bus.cursor), 80'(0));
        pulse(1'b1, 1'b0, 1'b0);
        chk("left_wrap", 80'(bus.cursor), 80'(15));
        pulse(1'b1, 1'b1, 1'b0);
        chk("both_dirs", 80'(bus.cursor), 80'(15));
        pulse(1'b0, 1'b1, 1'b0);
        chk("right_wrap", 80'(bus.cursor), 80'(0));

        // Select card 0 twice; select plus move discards the move
        sel_card(0);
        sel_card(0);
        pulse(1'b0, 1'b1, 1'b1);
        chk("sel_move_cursor", 80'(bus.cursor), 80'(0));
        chk("sel_move_board", bus.arr_cards_out, exp_board);

        // Matching pair 0/1, still in UNA so card 1 ends the turn
        sel_card(1);
        resolve(0, 1, 5, 1'b0);
        sel_card(1);

        // Mismatched pair 2/4 with button noise in MOSTRAR and ESPERAR
        sel_card(2);
        sel_card(4);
        pulse(1'b1, 1'b0, 1'b1);
        chk("mostrar_btn_cursor", 80'(bus.cursor), 80'(4));
        chk("mostrar_btn_board", bus.arr_cards_out, exp_board);
        resolve(2, 4, 4, 1'b1);

        // verif_done outside ESPERAR is ignored
        full = b0;
        for (int i = 0; i < NUM_CARTAS; i++) full[i] = {b0[i][4:2], EMPAREJADA};
        bus.arr_verif_in = full;
        bus.verif_done = 1'b1;
        bus.verif_pareja = 1'b1;
        tick();
        bus.verif_done = 1'b0;
        bus.verif_pareja = 1'b0;
        chk("idle_done_board", bus.arr_cards_out, exp_board);
        chk("idle_done_turno", 80'(bus.turno_fin), 80'(0));
        chk("idle_done_intentos", 80'(bus.intentos), 80'(exp_intentos));

        // Finish the game
        for (int p = 1; p < 8; p++) begin
            chk("not_fin_yet", 80'(bus.juego_fin), 80'(0));
            play_pair(2 * p, 2 * p + 1);
        end
        chk("juego_fin", 80'(bus.juego_fin), 80'(1));
        chk("fin_intentos", 80'(bus.intentos), 80'(9));
        pulse(1'b0, 1'b1, 1'b0);
        chk("fin_cursor_frozen", 80'(bus.cursor), 80'(15));
        pulse(1'b0, 1'b0, 1'b1);
        chk("fin_board_frozen", bus.arr_cards_out, full);
        chk("fin_hold", 80'(bus.juego_fin), 80'(1));
        load_board(b0);
        chk("reload_fin", 80'(bus.juego_fin), 80'(0));
        chk("reload_intentos", 80'(bus.intentos), 80'(0));
        chk("reload_cursor", 80'(bus.cursor), 80'(0));

        // Attempt counter saturation
        for (int t = 0; t < 256; t++) play_pair(2, 1);
        chk("intentos_sat", 80'(bus.intentos), 80'(255));

        // Reset in ESPERAR, then a late verif_done
        load_board(b0);
        sel_card(0);
        sel_card(1);
        begin
            int n;
            n = 0;
            while (!bus.start_verif && n < 40) begin
                tick();
                n++;
            end
            chk("pre_rst_start", 80'(bus.start_verif), 80'(1));
        end
        rst = 1'b0;
        #1;
        chk("async_rst_board", bus.arr_cards_out, 80'(0));
        chk("async_rst_start", 80'(bus.start_verif), 80'(0));
        tick();
        rst = 1'b1;
        tick();
        full = b0;
        full[0] = {b0[0][4:2], EMPAREJADA};
        full[1] = {b0[1][4:2], EMPAREJADA};
        bus.arr_verif_in = full;
        bus.verif_done = 1'b1;
        bus.verif_pareja = 1'b1;
        tick();
        bus.verif_done = 1'b0;
        bus.verif_pareja = 1'b0;
        chk("late_done_board", bus.arr_cards_out, 80'(0));
        chk("late_done_intentos", 80'(bus.intentos), 80'(0));
        for (int i = 0; i < 8; i++) begin
            chk("late_no_pulse", 80'({bus.turno_fin, bus.pareja, bus.start_verif}), 80'(0));
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
